// File: rtl/ddr4_lane_dly_step_ctrl.sv
// ddr4_lane_dly_step_ctrl
//
// Sequences one delay-line training request for a DDR4 lane controller.
// A request raises HS_IO_CLK_PAUSE, issues spaced DELAY_LINE_MOVE pulses
// (or a single DELAY_LINE_LOAD), watches the selected line's out-of-range
// flag, releases the pause and reports status with a one-cycle DONE.
// A tracked tap position is kept for each delay line.
//
// Ports
//   FAB_CLK, ARST_N                 clock, async active-low reset
//   REQ_VALID / REQ_READY           request handshake (ready only in IDLE)
//   REQ_SEL, REQ_DIR, REQ_LOAD      line select (1=TX), direction (1=inc), reload
//   REQ_TAPS                        number of move pulses (0 legal)
//   RX/TX_DELAY_LINE_OUT_OF_RANGE   range flags from the lane controller
//   DELAY_LINE_SEL/DIRECTION        registered request fields to the lane
//   DELAY_LINE_MOVE/LOAD            single-cycle pulses to the lane
//   HS_IO_CLK_PAUSE                 pause request to the lane synchroniser
//   DONE, DONE_OOR, DONE_TAPS       completion pulse and status
//   RX_TAP_POS, TX_TAP_POS          tracked tap positions
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request
// PAUSE   | pause held PAUSE_SETUP cycles before the first pulse
// MOVE    | one pulse cycle (move or load), tap position updated
// GAP     | MOVE_GAP quiet cycles, selected range flag sampled
// RELEASE | pause dropped, PAUSE_HOLD cycles of settling
// DONE    | one-cycle completion status
module ddr4_lane_dly_step_ctrl #(
    parameter int         PAUSE_SETUP = 4,
    parameter int         MOVE_GAP    = 3,
    parameter int         PAUSE_HOLD  = 4,
    parameter logic [7:0] INIT_TAP    = 8'd1
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_SEL,
    input  logic       REQ_DIR,
    input  logic       REQ_LOAD,
    input  logic [7:0] REQ_TAPS,
    input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_LOAD,
    output logic       HS_IO_CLK_PAUSE,
    output logic       DONE,
    output logic       DONE_OOR,
    output logic [7:0] DONE_TAPS,
    output logic [7:0] RX_TAP_POS,
    output logic [7:0] TX_TAP_POS
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_MOVE,
        S_GAP,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETUP_LOAD = 4'(PAUSE_SETUP - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(MOVE_GAP - 1);
    localparam logic [3:0] HOLD_LOAD  = 4'(PAUSE_HOLD - 1);

    state_t     state;
    logic [3:0] timer;
    logic       sel_q;
    logic       dir_q;
    logic       load_q;
    logic [7:0] taps_q;
    logic [7:0] issued;
    logic       abort;

    logic       oor_sel;
    logic       more_pulses;

    // Only the selected line's flag matters; it is only looked at in GAP.
    assign oor_sel     = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
    // Decision at the last GAP cycle includes that cycle's own flag sample.
    assign more_pulses = !(abort || oor_sel) && !load_q && (issued != taps_q);

    function automatic logic [7:0] tap_step(input logic [7:0] pos, input logic inc);
        if (inc) return (pos == 8'hFF) ? pos : pos + 8'd1;
        else     return (pos == 8'h00) ? pos : pos - 8'd1;
    endfunction

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state                <= S_IDLE;
            timer                <= 4'd0;
            sel_q                <= 1'b0;
            dir_q                <= 1'b0;
            load_q               <= 1'b0;
            taps_q               <= 8'd0;
            issued               <= 8'd0;
            abort                <= 1'b0;
            REQ_READY            <= 1'b1;
            DELAY_LINE_SEL       <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
            HS_IO_CLK_PAUSE      <= 1'b0;
            DONE                 <= 1'b0;
            DONE_OOR             <= 1'b0;
            DONE_TAPS            <= 8'd0;
            RX_TAP_POS           <= INIT_TAP;
            TX_TAP_POS           <= INIT_TAP;
        end else begin
            DELAY_LINE_MOVE <= 1'b0;
            DELAY_LINE_LOAD <= 1'b0;
            DONE            <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        sel_q                <= REQ_SEL;
                        dir_q                <= REQ_DIR;
                        load_q               <= REQ_LOAD;
                        taps_q               <= REQ_TAPS;
                        issued               <= 8'd0;
                        abort                <= 1'b0;
                        DELAY_LINE_SEL       <= REQ_SEL;
                        DELAY_LINE_DIRECTION <= REQ_DIR;
                        HS_IO_CLK_PAUSE      <= 1'b1;
                        REQ_READY            <= 1'b0;
                        timer                <= SETUP_LOAD;
                        state                <= S_PAUSE;
                    end
                end

                S_PAUSE: begin
                    if (timer == 4'd0) begin
                        if (load_q || (taps_q != 8'd0)) begin
                            DELAY_LINE_LOAD <= load_q;
                            DELAY_LINE_MOVE <= !load_q;
                            state           <= S_MOVE;
                        end else begin
                            HS_IO_CLK_PAUSE <= 1'b0;
                            timer           <= HOLD_LOAD;
                            state           <= S_RELEASE;
                        end
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end

                S_MOVE: begin
                    if (load_q) begin
                        if (sel_q) TX_TAP_POS <= INIT_TAP;
                        else       RX_TAP_POS <= INIT_TAP;
                    end else begin
                        issued <= issued + 8'd1;
                        if (sel_q) TX_TAP_POS <= tap_step(TX_TAP_POS, dir_q);
                        else       RX_TAP_POS <= tap_step(RX_TAP_POS, dir_q);
                    end
                    timer <= GAP_LOAD;
                    state <= S_GAP;
                end

                S_GAP: begin
                    if (oor_sel) abort <= 1'b1;
                    if (timer == 4'd0) begin
                        if (more_pulses) begin
                            DELAY_LINE_MOVE <= 1'b1;
                            state           <= S_MOVE;
                        end else begin
                            HS_IO_CLK_PAUSE <= 1'b0;
                            timer           <= HOLD_LOAD;
                            state           <= S_RELEASE;
                        end
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end

                S_RELEASE: begin
                    if (timer == 4'd0) begin
                        DONE      <= 1'b1;
                        DONE_OOR  <= abort;
                        DONE_TAPS <= issued;
                        state     <= S_DONE;
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end

                S_DONE: begin
                    REQ_READY <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    REQ_READY <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ddr4_lane_dly_step_ctrl.md
# ddr4_lane_dly_step_ctrl

Sequencer that sits directly upstream of the DDR4 lane controller and drives its delay-line control inputs. It turns one training request (select RX/TX DQS line, direction, tap count or reload) into a pause-protected sequence. The sequence raises HS_IO_CLK_PAUSE, issues spaced DELAY_LINE_MOVE or DELAY_LINE_LOAD pulses, watches the lane's out-of-range flags, releases the pause, and reports a status. It also keeps a tracked tap position for each delay line.

## Interface
Parameters:
- PAUSE_SETUP, 4: cycles HS_IO_CLK_PAUSE is held before the first pulse; 1..15.
- MOVE_GAP, 3: idle cycles after each pulse; 1..15.
- PAUSE_HOLD, 4: cycles after pause release before DONE; 1..15.
- INIT_TAP, 1: tap position after reset and after a load.

Ports:
- FAB_CLK, in, 1: fabric clock; all logic is on this clock.
- ARST_N, in, 1: asynchronous, active-low reset.
- REQ_VALID, in, 1: request strobe.
- REQ_READY, out, 1: high only in IDLE.
- REQ_SEL, in, 1: 0 = RX DQS line, 1 = TX DQS line.
- REQ_DIR, in, 1: 1 = increment, 0 = decrement.
- REQ_LOAD, in, 1: 1 = reload the delay line to its configured value; REQ_TAPS is ignored.
- REQ_TAPS, in, 8: number of move pulses; 0 is legal.
- RX_DELAY_LINE_OUT_OF_RANGE, in, 1: flag from the lane controller.
- TX_DELAY_LINE_OUT_OF_RANGE, in, 1: flag from the lane controller.
- DELAY_LINE_SEL, out, 1: to the lane controller.
- DELAY_LINE_DIRECTION, out, 1: to the lane controller.
- DELAY_LINE_MOVE, out, 1: to the lane controller; single-cycle pulses.
- DELAY_LINE_LOAD, out, 1: to the lane controller; single-cycle pulse.
- HS_IO_CLK_PAUSE, out, 1: to the lane controller pause synchroniser.
- DONE, out, 1: one-cycle completion pulse.
- DONE_OOR, out, 1: valid with DONE; high when the sequence aborted on out-of-range.
- DONE_TAPS, out, 8: valid with DONE; number of move pulses actually issued.
- RX_TAP_POS, out, 8: tracked RX tap position.
- TX_TAP_POS, out, 8: tracked TX tap position.

## Operation
- States: IDLE, PAUSE, MOVE, GAP, RELEASE, DONE.
- IDLE:
  - REQ_READY=1.
  - When REQ_VALID=1, the request is accepted. SEL, DIR, LOAD and TAPS are registered, and the state goes to PAUSE.
- PAUSE:
  - HS_IO_CLK_PAUSE=1 for PAUSE_SETUP cycles.
  - Next state is MOVE if LOAD=1 or TAPS>0; otherwise RELEASE.
- MOVE:
  - One cycle. DELAY_LINE_LOAD=1 if LOAD=1, else DELAY_LINE_MOVE=1.
  - On a move, the issued-count register increments.
  - The selected position register updates: +1 if DIR=1, −1 if DIR=0, saturating at 255 and 0.
  - On a load, the selected position register is set to INIT_TAP.
  - Next state is GAP.
- GAP:
  - MOVE_GAP cycles with all pulse outputs low.
  - The out-of-range flag of the selected line is sampled every GAP cycle. Any high sample sets an abort flag.
  - At the end of GAP:
    - If the abort flag is set, or the operation was a load, or issued count = TAPS, go to RELEASE.
    - Otherwise go back to MOVE.
- RELEASE:
  - HS_IO_CLK_PAUSE=0 for PAUSE_HOLD cycles.
  - Next state is DONE.
- DONE:
  - One cycle. DONE=1, DONE_OOR = abort flag, DONE_TAPS = issued count (0 for a load or a zero-tap request).
  - Next state is IDLE.
- DELAY_LINE_SEL and DELAY_LINE_DIRECTION:
  - Driven from the registered request, from the cycle after acceptance through the end of RELEASE.
  - Hold their last value otherwise.
- The out-of-range flags are ignored outside GAP. The flag of the non-selected line is always ignored.
- REQ_VALID outside IDLE is ignored; no queueing.
- All outputs are registered.

## Timing
- Reset values:
  - REQ_READY=1; state IDLE.
  - DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE, DELAY_LINE_LOAD, HS_IO_CLK_PAUSE, DONE, DONE_OOR = 0; DONE_TAPS=0.
  - RX_TAP_POS = TX_TAP_POS = INIT_TAP.
- The first bullets use symbols:
  - T = acceptance cycle.
  - P = PAUSE_SETUP, G = MOVE_GAP, H = PAUSE_HOLD.
  - N = pulses issued (a load counts as one pulse for timing).
- HS_IO_CLK_PAUSE is high from T+1 through T+P+N·(1+G).
- Pulse k (k = 0..N−1) occurs at T+1+P+k·(1+G).
- DONE is at T+1+P+N·(1+G)+H. REQ_READY is high again at DONE+1.
- With default parameters:
  - N=2: pulses at T+5 and T+9, pause high T+1..T+12, DONE at T+17.
  - Zero taps: DONE at T+9.
  - Load: DONE at T+13.
- Abort: if out-of-range is sampled high in the GAP after pulse k, no further pulses are issued. DONE_TAPS=k+1 and DONE_OOR=1. The remaining timing follows the formula with N=k+1.
- Position saturation does not stop the pulses. DONE_TAPS counts issued pulses, not position change.
- ARST_N asserted mid-sequence: all outputs go to reset values immediately. The pause drops asynchronously, no DONE is produced, and positions return to INIT_TAP.

## Test plan
- After reset, RX request DIR=1, TAPS=2 -> pulses at T+5 and T+9 with SEL=0, DIR=1; pause high T+1..T+12; DONE at T+17 with DONE_TAPS=2, DONE_OOR=0; RX_TAP_POS=3.
- TX request, TAPS=0 -> no pulses; pause high T+1..T+4; DONE at T+9 with DONE_TAPS=0; TX_TAP_POS stays 1.
- TX request DIR=1, TAPS=10; TX_DELAY_LINE_OUT_OF_RANGE raised at T+14 (GAP after the third pulse) -> exactly 3 pulses; DONE at T+21 with DONE_OOR=1, DONE_TAPS=3, TX_TAP_POS=4. Also check that RX_DELAY_LINE_OUT_OF_RANGE raised during an RX-unselected run does not abort.
- RX request DIR=0, TAPS=5 from position 1 -> 5 pulses issued; RX_TAP_POS saturates at 0; DONE_TAPS=5. Then a load request -> single DELAY_LINE_LOAD pulse at T+5; DONE at T+13; RX_TAP_POS=1.
- ARST_N pulsed low at T+7 of a 4-tap request -> HS_IO_CLK_PAUSE low immediately; no DONE; REQ_READY=1 after release; a following 1-tap request completes normally with DONE at T+13.
- REQ_VALID held high continuously -> back-to-back requests are accepted only at IDLE cycles, one cycle after each DONE.
